// File: rtl/apb_cfg_master.sv
// APB3 initiator for the bnn_cfg port: one SETUP/ACCESS transfer per command,
// response held on a valid/ready port; ACCESS aborts after TIMEOUT cycles without pready.
module apb_cfg_master #(
    parameter int unsigned ADDR_W  = 13,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic              busy,
    output logic [ADDR_W-1:0] paddr,
    output logic              pwrite,
    output logic              psel,
    output logic              penable,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    typedef enum logic [1:0] {StIdle, StSetup, StAccess, StResp} state_e;

    localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

    state_e              state_q, state_d;
    logic [15:0]         cnt_q, cnt_d;
    logic                timeout_hit;

    logic [ADDR_W-1:0]   paddr_d;
    logic [DATA_W-1:0]   pwdata_d, rsp_rdata_d;
    logic                pwrite_d, psel_d, penable_d, busy_d;
    logic                rsp_valid_d, rsp_err_d, rsp_timeout_d;

    assign cmd_ready   = (state_q == StIdle);
    // pready on the last allowed cycle still counts as a normal completion
    assign timeout_hit = (cnt_q == CntLast) && !pready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (cmd_valid) state_d = StSetup;
            StSetup:  state_d = StAccess;
            StAccess: if (pready || timeout_hit) state_d = StResp;
            StResp:   if (rsp_ready) state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_q;
        paddr_d       = paddr;
        pwrite_d      = pwrite;
        pwdata_d      = pwdata;
        psel_d        = psel;
        penable_d     = penable;
        busy_d        = busy;
        rsp_valid_d   = rsp_valid;
        rsp_rdata_d   = rsp_rdata;
        rsp_err_d     = rsp_err;
        rsp_timeout_d = rsp_timeout;
        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    paddr_d   = cmd_addr;
                    pwrite_d  = cmd_write;
                    pwdata_d  = cmd_write ? cmd_wdata : '0;
                    psel_d    = 1'b1;
                    penable_d = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            StSetup: begin
                penable_d = 1'b1;
                cnt_d     = '0;
            end
            StAccess: begin
                if (pready) begin
                    rsp_rdata_d   = pwrite ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                end else if (timeout_hit) begin
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    rsp_valid_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            paddr       <= '0;
            pwrite      <= 1'b0;
            pwdata      <= '0;
            psel        <= 1'b0;
            penable     <= 1'b0;
            busy        <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            paddr       <= paddr_d;
            pwrite      <= pwrite_d;
            pwdata      <= pwdata_d;
            psel        <= psel_d;
            penable     <= penable_d;
            busy        <= busy_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_err     <= rsp_err_d;
            rsp_timeout <= rsp_timeout_d;
        end
    end

endmodule

// File: tb/tb_apb_cfg_master.sv
// Randomized bench for apb_cfg_master: APB slave model with programmable wait/error,
// transaction-level reference memory and per-cycle protocol/latency expectations.
module tb_apb_cfg_master;

    localparam int unsigned AW = 13;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] paddr;
    logic          pwrite, psel, penable, pready, pslverr;
    logic [DW-1:0] pwdata, prdata;

    apb_cfg_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .busy(busy),
        .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable), .pwdata(pwdata),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Slave keeps its own storage; the reference keeps a separate copy.
    logic [31:0] slv_mem [0:8191];
    logic [31:0] ref_mem [0:8191];
    int          slv_wait = 0;
    bit          slv_err  = 1'b0;
    int          acc_n    = 0;

    always @(negedge clk) begin
        if (psel && penable) begin
            pready  = (acc_n == slv_wait);
            pslverr = slv_err;
            if (pready) begin
                prdata = slv_mem[paddr];
                if (pwrite && !slv_err) slv_mem[paddr] = pwdata;
            end else begin
                prdata = $urandom;
            end
            acc_n++;
        end else begin
            pready  = 1'($urandom);
            pslverr = 1'($urandom);
            prdata  = $urandom;
            acc_n   = 0;
        end
    end

    task automatic do_xfer(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input int waits, input bit serr, input int dly);
        int          n;
        int          rcyc;
        bit          to;
        logic [31:0] exp_rd;
        to     = (waits >= int'(TO));
        exp_rd = (wr || to) ? 32'h0 : ref_mem[a];
        rcyc   = 3 + ((waits < int'(TO)) ? waits : int'(TO) - 1);
        slv_wait  = waits;
        slv_err   = serr;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        rsp_ready = (dly == 0);
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) begin
            check("cmd_accept", 32'(cmd_ready), 32'h1);
            cmd_valid = 1'b0;
            return;
        end
        for (n = 1; n <= rcyc + 4; n++) begin
            @(negedge clk);
            if (n == 1) begin
                cmd_valid = 1'b0;
                cmd_wdata = $urandom;
                cmd_addr  = AW'($urandom);
            end
            if (rsp_valid) break;
            check("psel", 32'(psel), 32'h1);
            check("penable", 32'(penable), 32'(n >= 2));
            check("busy", 32'(busy), 32'h1);
            check("paddr", 32'(paddr), 32'(a));
            check("pwrite", 32'(pwrite), 32'(wr));
            check("pwdata", pwdata, wr ? d : 32'h0);
        end
        check("rsp_cycle", 32'(n), 32'(rcyc));
        if (!rsp_valid) return;
        if (wr && !(to || serr)) ref_mem[a] = d;
        for (int k = 0; k <= dly; k++) begin
            if (k != 0) @(negedge clk);
            check("rsp_valid", 32'(rsp_valid), 32'h1);
            check("rsp_rdata", rsp_rdata, exp_rd);
            check("rsp_err", 32'(rsp_err), 32'(to || serr));
            check("rsp_timeout", 32'(rsp_timeout), 32'(to));
            check("resp_idle_bus", {30'h0, psel, penable}, 32'h0);
            check("resp_cmd_ready", 32'(cmd_ready), 32'h0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_rsp_valid", 32'(rsp_valid), 32'h0);
        check("post_cmd_ready", 32'(cmd_ready), 32'h1);
        check("post_busy", 32'(busy), 32'h0);
    endtask

    task automatic burst(input int count);
        int          i = 0;
        int          r = 0;
        int          cyc = 0;
        int          t0 = 0;
        int          t1 = -1;
        logic [31:0] wd;
        slv_wait  = 0;
        slv_err   = 1'b0;
        rsp_ready = 1'b1;
        wd = $urandom;
        while (r < count && cyc < 2000) begin
            cmd_valid = (i < count);
            cmd_write = 1'b1;
            cmd_addr  = AW'(13'h400 + 13'(i));
            cmd_wdata = wd;
            if (cmd_valid && cmd_ready) begin
                if (i == 0) t0 = cyc;
                ref_mem[cmd_addr] = wd;
                wd = $urandom;
                i++;
            end
            if (rsp_valid) begin
                check("burst_err", 32'(rsp_err), 32'h0);
                r++;
                t1 = cyc;
            end
            @(negedge clk);
            cyc++;
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        check("burst_rsps", 32'(r), 32'(count));
        check("burst_cycles", 32'(t1 - t0 + 1), 32'(4 * count));
    endtask

    int wait_pick [6] = '{5, 1, 6, 7, 8, 11};

    initial begin
        for (int i = 0; i < 8192; i++) begin
            slv_mem[i] = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
            ref_mem[i] = 32'(i) * 32'h9E37_79B1 ^ 32'h5A5A_0000;
        end
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_bus", {29'h0, psel, penable, pwrite}, 32'h0);
        check("rst_paddr", 32'(paddr), 32'h0);
        check("rst_pwdata", pwdata, 32'h0);
        check("rst_rsp", {28'h0, rsp_valid, rsp_err, rsp_timeout, busy}, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'h1);
        rst = 1'b0;
        @(negedge clk);

        do_xfer(1'b1, 13'h010, 32'hA5A5_0001, 0, 1'b0, 0);   // zero-wait write
        do_xfer(1'b1, 13'h1F0, 32'h0000_0003, 0, 1'b0, 0);
        do_xfer(1'b0, 13'h1F0, 32'h0, 3, 1'b0, 0);            // 3 wait states
        do_xfer(1'b0, 13'h022, 32'h0, 0, 1'b1, 1);            // slave error
        do_xfer(1'b0, 13'h033, 32'h0, 20, 1'b0, 0);           // timeout
        do_xfer(1'b0, 13'h034, 32'h0, TO - 1, 1'b0, 0);       // pready on last cycle
        do_xfer(1'b1, 13'h035, 32'h1234_5678, 0, 1'b0, 5);    // backpressure
        do_xfer(1'b0, 13'h035, 32'h0, 1, 1'b0, 0);

        // reset while penable is high
        slv_wait = 6;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 13'h055;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_penable", 32'(penable), 32'h1);
        rst = 1'b1;
        #1;
        check("midrst_bus", {29'h0, psel, penable, busy}, 32'h0);
        check("midrst_rsp_valid", 32'(rsp_valid), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("post_rst_idle", {30'h0, rsp_valid, busy}, 32'h0);
        do_xfer(1'b0, 13'h055, 32'h0, 2, 1'b0, 0);

        for (int t = 0; t < 40; t++) begin
            int w;
            w = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 3))
                                            : wait_pick[$urandom_range(0, 5)];
            do_xfer(1'($urandom), AW'($urandom_range(0, 63)), $urandom, w,
                    ($urandom_range(0, 5) == 0), int'($urandom_range(0, 3)));
        end

        burst(108);
        for (int t = 0; t < 6; t++) begin
            do_xfer(1'b0, AW'(13'h400 + 13'($urandom_range(0, 107))), 32'h0, 0, 1'b0, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
